audio_mixer_dac: RTL
====================

// Module: audio_mixer_dac
// PURPOSE
//  Parametrised N-channel audio mixer feeding the MiSTer AUDIO_L/AUDIO_R pins, replacing the fixed single-channel dac.
//  Per-channel volume, mute and L/R routing; saturating sum; 16-bit signed PCM out.
//  First-order sigma-delta 1-bit stream per side for pin-level DAC use.
//  Sits between core sound sources (beeper, tape monitor, AY) and the emu top.
// PARAMETERS
//  CHANNELS  2   number of input channels (1..8)
//  IN_W      8   width of each unsigned (offset-binary) channel sample
//  VOL_W     4   width of per-channel volume; 0 = silent, 2^VOL_W-1 = full
//  OUT_W     16  PCM output width; constraint OUT_W >= IN_W+VOL_W
// PORTS
//  clk_sys     in   1                 system clock; all logic on rising edge
//  reset       in   1                 synchronous, active-high
//  ce_sample   in   1                 one-cycle strobe: start mixing one sample
//  ch_data     in   CHANNELS*IN_W     channel k at [k*IN_W +: IN_W], unsigned
//  ch_vol      in   CHANNELS*VOL_W    channel k volume at [k*VOL_W +: VOL_W]
//  ch_mute     in   CHANNELS          1 = channel k contributes 0
//  ch_route    in   2*CHANNELS        bit 2k = to left, bit 2k+1 = to right
//  audio_l     out  OUT_W             signed PCM, left
//  audio_r     out  OUT_W             signed PCM, right
//  sample_vld  out  1                 one-cycle pulse when audio_l/r update
//  clip        out  1                 pulse with sample_vld if either side saturated
//  overrun     out  1                 one-cycle pulse: ce_sample arrived while busy
//  dsm_l       out  1                 sigma-delta bitstream of audio_l
//  dsm_r       out  1                 sigma-delta bitstream of audio_r
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, accumulators and DSM integrators 0.
//  Synchronous reset mid-operation aborts; no sample_vld; audio_l/r hold 0.
//  Inputs sampled per channel during ACC; must stay stable for CHANNELS cycles after ce_sample.
//  FSM: IDLE -(ce_sample)-> ACC; ACC iterates k=0..CHANNELS-1, one channel/cycle;
//   after k=CHANNELS-1 -> SAT; SAT -> IDLE (one cycle).
//  Latency: ce_sample at cycle t -> sample_vld at t+CHANNELS+1 (t+3 at defaults).
//  ACC step: sx = {~d[IN_W-1], d[IN_W-2:0]} signed; term = sx * vol (IN_W+VOL_W signed);
//   term forced 0 if ch_mute[k]; added to acc_l if route bit 2k, acc_r if 2k+1.
//  Accumulators: IN_W+VOL_W+clog2(CHANNELS)+1 bits, cleared on entering ACC.
//  SAT: clamp each acc to signed IN_W+VOL_W range [-2^(IN_W+VOL_W-1), 2^(IN_W+VOL_W-1)-1],
//   then audio_x = clamped <<< (OUT_W-IN_W-VOL_W); clip = 1 if either clamped.
//  audio_l/r registered, update only in SAT cycle, else hold.
//  ce_sample in ACC or SAT: ignored, overrun pulses next cycle; ce_sample in IDLE same
//   cycle as SAT completion is accepted (no overrun).
//  DSM (every clk_sys cycle): u = audio_x ^ (1<<(OUT_W-1)) (unsigned);
//   {c, integ} = integ + u (OUT_W+1 bits); dsm_x <= c. Ones density = u/2^OUT_W.
//  Routing bits 0 for a channel: contributes to neither side; all-zero mix gives output 0.
// TESTING (defaults: CHANNELS=2, IN_W=8, VOL_W=4, OUT_W=16)
//  ch0=0xFF vol 15 route L, ch1 muted; pulse ce -> 3 cycles later sample_vld,
//   audio_l=0x7710 (127*15=1905<<4), audio_r=0x0000, clip=0.
//  both ch=0xFF vol 15 route L+R -> audio_l=audio_r=0x7FF0, clip=1; both ch=0x00 -> 0x8000, clip=1.
//  ch0=0x80 vol 15, ch1=0x40 vol 2 route R -> audio_r=(0+(-64*2))<<4=0xF800, audio_l=0.
//  ce at t and t+1 -> overrun pulse at t+2, single sample_vld at t+3, result of first only.
//  reset asserted at t+1 after ce -> no sample_vld, audio_l/r=0, next ce mixes normally.
//  audio_l=0x0000 held 65536 cycles -> dsm_l ones count 32768+-1; audio_l=0x8000 -> 0 ones.

Source files
------------

// File: rtl/audio_mixer_dac.sv
// audio_mixer_dac: N-channel mixer with per-channel volume, mute and L/R
// routing, saturating signed PCM outputs and first-order sigma-delta streams.
module audio_mixer_dac #(
    parameter int CHANNELS = 2,
    parameter int IN_W     = 8,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce_sample,
    input  logic [CHANNELS*IN_W-1:0]  ch_data,
    input  logic [CHANNELS*VOL_W-1:0] ch_vol,
    input  logic [CHANNELS-1:0]       ch_mute,
    input  logic [2*CHANNELS-1:0]     ch_route,
    output logic [OUT_W-1:0]          audio_l,
    output logic [OUT_W-1:0]          audio_r,
    output logic                      sample_vld,
    output logic                      clip,
    output logic                      overrun,
    output logic                      dsm_l,
    output logic                      dsm_r
);

    localparam int TW    = IN_W + VOL_W;
    localparam int ACC_W = TW + $clog2(CHANNELS) + 1;
    localparam int SH    = OUT_W - TW;
    localparam int KW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((2 ** (TW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;
    localparam logic [OUT_W-1:0] C_MSB = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [KW-1:0]           r_k;
    logic signed [ACC_W-1:0] r_acc_l;
    logic signed [ACC_W-1:0] r_acc_r;

    logic                    w_clr;
    logic                    w_acc_en;
    logic                    w_last;
    logic                    w_ovr;

    logic [IN_W-1:0]         w_d [CHANNELS];
    logic [VOL_W-1:0]        w_v [CHANNELS];
    logic [IN_W-1:0]         w_din;
    logic [VOL_W-1:0]        w_vin;
    logic                    w_mute;
    logic                    w_to_l;
    logic                    w_to_r;
    logic signed [IN_W-1:0]  w_sx;
    logic signed [ACC_W-1:0] w_sx_e;
    logic signed [ACC_W-1:0] w_vol_e;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_nxt_l;
    logic signed [ACC_W-1:0] w_nxt_r;

    logic [TW:0]             w_sat_l;
    logic [TW:0]             w_sat_r;
    logic signed [TW-1:0]    w_cl_l;
    logic signed [TW-1:0]    w_cl_r;
    logic signed [OUT_W-1:0] w_ext_l;
    logic signed [OUT_W-1:0] w_ext_r;

    logic [OUT_W-1:0]        r_int_l;
    logic [OUT_W-1:0]        r_int_r;
    logic [OUT_W:0]          w_sum_l;
    logic [OUT_W:0]          w_sum_r;

    // Clamp to the signed TW-bit range; top bit flags that clamping happened.
    function automatic logic [TW:0] sat_fn(input logic signed [ACC_W-1:0] a);
        if (a > C_MAX) begin
            return {1'b1, C_MAX[TW-1:0]};
        end else if (a < C_MIN) begin
            return {1'b1, C_MIN[TW-1:0]};
        end else begin
            return {1'b0, a[TW-1:0]};
        end
    endfunction

    // Unpack the flat channel buses so the active channel can be indexed by r_k.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_d[i] = ch_data[i*IN_W +: IN_W];
            w_v[i] = ch_vol[i*VOL_W +: VOL_W];
        end
    end

    assign w_din   = w_d[r_k];
    assign w_vin   = w_v[r_k];
    assign w_mute  = ch_mute[r_k];
    assign w_to_l  = ch_route[{r_k, 1'b0}];
    assign w_to_r  = ch_route[{r_k, 1'b1}];
    assign w_sx    = {~w_din[IN_W-1], w_din[IN_W-2:0]};
    assign w_sx_e  = ACC_W'(w_sx);
    assign w_vol_e = ACC_W'(w_vin);
    assign w_term  = w_mute ? '0 : w_sx_e * w_vol_e;
    assign w_nxt_l = w_to_l ? r_acc_l + w_term : r_acc_l;
    assign w_nxt_r = w_to_r ? r_acc_r + w_term : r_acc_r;

    // The last channel's sum is clamped on the fly so the result lands in SAT.
    assign w_sat_l = sat_fn(w_nxt_l);
    assign w_sat_r = sat_fn(w_nxt_r);
    assign w_cl_l  = w_sat_l[TW-1:0];
    assign w_cl_r  = w_sat_r[TW-1:0];
    assign w_ext_l = OUT_W'(w_cl_l);
    assign w_ext_r = OUT_W'(w_cl_r);

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one ACC cycle per channel, then a single SAT cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ce_sample) w_next = S_ACC;
            S_ACC:   if (r_k == K_LAST) w_next = S_SAT;
            S_SAT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        w_clr    = (r_state == S_IDLE) && ce_sample;
        w_acc_en = (r_state == S_ACC);
        w_last   = (r_state == S_ACC) && (r_k == K_LAST);
        w_ovr    = (r_state != S_IDLE) && ce_sample;
    end

    // Channel counter and accumulators, cleared when a new sample starts.
    always_ff @(posedge clk_sys) begin
        if (reset || w_clr) begin
            r_k     <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (w_acc_en) begin
            r_k     <= r_k + KW'(1);
            r_acc_l <= w_nxt_l;
            r_acc_r <= w_nxt_r;
        end
    end

    // PCM outputs and status pulses; audio holds between samples.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            audio_l    <= '0;
            audio_r    <= '0;
            sample_vld <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sample_vld <= w_last;
            clip       <= w_last && (w_sat_l[TW] || w_sat_r[TW]);
            overrun    <= w_ovr;
            if (w_last) begin
                audio_l <= w_ext_l <<< SH;
                audio_r <= w_ext_r <<< SH;
            end
        end
    end

    assign w_sum_l = {1'b0, r_int_l} + {1'b0, audio_l ^ C_MSB};
    assign w_sum_r = {1'b0, r_int_r} + {1'b0, audio_r ^ C_MSB};

    // First-order sigma-delta: the integrator carry is the output bit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_int_l <= '0;
            r_int_r <= '0;
            dsm_l   <= 1'b0;
            dsm_r   <= 1'b0;
        end else begin
            r_int_l <= w_sum_l[OUT_W-1:0];
            r_int_r <= w_sum_r[OUT_W-1:0];
            dsm_l   <= w_sum_l[OUT_W];
            dsm_r   <= w_sum_r[OUT_W];
        end
    end

endmodule
